// File: rtl/nes_frame_buffer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// nes_frame_buffer_if
// Pixel write handshake and random-access read port of the NES frame buffer.
// Revision: 1.0
// ============================================================================
interface nes_frame_buffer_if;
  logic       px_valid;
  logic       px_sof;
  logic [5:0] px_index;
  logic       px_ready;
  logic [7:0] rd_x;
  logic [7:0] rd_y;
  logic [8:0] rgb_buf;

  modport master (
    output px_valid, px_sof, px_index, rd_x, rd_y,
    input  px_ready, rgb_buf
  );

  modport slave (
    input  px_valid, px_sof, px_index, rd_x, rd_y,
    output px_ready, rgb_buf
  );
endinterface
`default_nettype wire

// File: rtl/nes_frame_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// nes_frame_buffer
// Single-frame store of 6-bit NES colour indices, read back as 3:3:3 RGB.
// Revision: 1.0
// ============================================================================
module nes_frame_buffer #(
  parameter int         FB_W        = 256,
  parameter int         FB_H        = 240,
  parameter logic [5:0] CLEAR_INDEX = 6'h0F
) (
  input  logic              pix_clk,
  input  logic              rst,
  nes_frame_buffer_if.slave fb,
  output logic              frame_done,
  output logic              overflow,
  output logic              busy
);

  localparam int              c_DEPTH     = FB_W * FB_H;
  localparam int              c_AW        = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
  localparam logic [c_AW-1:0] c_LAST_ADDR = c_AW'(c_DEPTH - 1);
  localparam logic [7:0]      c_X_LAST    = 8'(FB_W - 1);
  localparam logic [7:0]      c_Y_LAST    = 8'(FB_H - 1);

  localparam logic [1:0] c_ST_CLEAR    = 2'd0;
  localparam logic [1:0] c_ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] c_ST_RUN      = 2'd2;
  localparam logic [1:0] c_ST_FULL     = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic [c_AW-1:0] r_clr_addr;
  logic [7:0]      r_wr_x;
  logic [7:0]      r_wr_y;
  logic            r_frame_done;
  logic            r_overflow;
  logic            r_rd_blank;
  logic [5:0]      r_rd_data;
  logic [5:0]      r_mem [0:c_DEPTH-1];

  logic            w_xfer;
  logic            w_sof_xfer;
  logic            w_run_last;
  logic            w_rd_blank;
  logic            w_we;
  logic [c_AW-1:0] w_waddr;
  logic [c_AW-1:0] w_raddr;
  logic [c_AW-1:0] w_pix_addr;
  logic [5:0]      w_wdata;

  assign w_xfer     = fb.px_valid && (r_state != c_ST_CLEAR);
  assign w_sof_xfer = w_xfer && fb.px_sof;
  assign w_run_last = (r_state == c_ST_RUN) && w_xfer && !fb.px_sof &&
                      (r_wr_x == c_X_LAST) && (r_wr_y == c_Y_LAST);
  assign w_pix_addr = c_AW'(r_wr_y) * c_AW'(FB_W) + c_AW'(r_wr_x);

  // Off-frame lines and the whole clear sweep read as black.
  assign w_rd_blank = ({24'd0, fb.rd_y} >= 32'(FB_H)) || (r_state == c_ST_CLEAR);
  assign w_raddr    = w_rd_blank ? '0 : (c_AW'(fb.rd_y) * c_AW'(FB_W) + c_AW'(fb.rd_x));

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_CLEAR;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_CLEAR:    if (r_clr_addr == c_LAST_ADDR) w_next_state = c_ST_WAIT_SOF;
      c_ST_WAIT_SOF: if (w_sof_xfer)                w_next_state = c_ST_RUN;
      c_ST_RUN:      if (w_run_last)                w_next_state = c_ST_FULL;
      c_ST_FULL:     if (w_sof_xfer)                w_next_state = c_ST_RUN;
      default:                                      w_next_state = c_ST_CLEAR;
    endcase
  end

  always_comb begin
    fb.px_ready = 1'b1;
    busy        = 1'b0;
    w_we        = 1'b0;
    w_waddr     = '0;
    w_wdata     = fb.px_index;
    case (r_state)
      c_ST_CLEAR: begin
        fb.px_ready = 1'b0;
        busy        = 1'b1;
        w_we        = 1'b1;
        w_waddr     = r_clr_addr;
        w_wdata     = CLEAR_INDEX;
      end
      c_ST_WAIT_SOF, c_ST_FULL: begin
        w_we = w_sof_xfer;
      end
      c_ST_RUN: begin
        w_we    = w_xfer;
        w_waddr = fb.px_sof ? '0 : w_pix_addr;
      end
      default: begin
        w_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      r_clr_addr   <= '0;
      r_wr_x       <= 8'd0;
      r_wr_y       <= 8'd0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_rd_blank   <= 1'b1;
    end else begin
      r_frame_done <= w_run_last;
      r_rd_blank   <= w_rd_blank;
      if (r_state == c_ST_CLEAR) begin
        r_clr_addr <= r_clr_addr + c_AW'(1);
      end
      // A sof transfer always lands on (0,0) so the next pixel goes to (1,0).
      if (w_sof_xfer) begin
        r_wr_x     <= 8'd1;
        r_wr_y     <= 8'd0;
        r_overflow <= 1'b0;
      end else if (w_xfer && (r_state == c_ST_RUN)) begin
        if (r_wr_x == c_X_LAST) begin
          r_wr_x <= 8'd0;
          r_wr_y <= r_wr_y + 8'd1;
        end else begin
          r_wr_x <= r_wr_x + 8'd1;
        end
      end else if (w_xfer && (r_state == c_ST_FULL)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Non-blocking update gives read-before-write on a same-address collision.
  always_ff @(posedge pix_clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
    r_rd_data <= r_mem[w_raddr];
  end

  function automatic logic [8:0] f_palette(input logic [5:0] idx);
    logic [8:0] v;
    case (idx)
      6'h00: v = 9'o222; 6'h01: v = 9'o003; 6'h02: v = 9'o004; 6'h03: v = 9'o104;
      6'h04: v = 9'o203; 6'h05: v = 9'o201; 6'h06: v = 9'o200; 6'h07: v = 9'o100;
      6'h08: v = 9'o110; 6'h09: v = 9'o010; 6'h0A: v = 9'o020; 6'h0B: v = 9'o010;
      6'h0C: v = 9'o011;
      6'h10: v = 9'o444; 6'h11: v = 9'o026; 6'h12: v = 9'o117; 6'h13: v = 9'o207;
      6'h14: v = 9'o405; 6'h15: v = 9'o503; 6'h16: v = 9'o411; 6'h17: v = 9'o310;
      6'h18: v = 9'o220; 6'h19: v = 9'o130; 6'h1A: v = 9'o030; 6'h1B: v = 9'o031;
      6'h1C: v = 9'o033;
      6'h20: v = 9'o777; 6'h21: v = 9'o247; 6'h22: v = 9'o337; 6'h23: v = 9'o537;
      6'h24: v = 9'o727; 6'h25: v = 9'o725; 6'h26: v = 9'o733; 6'h27: v = 9'o641;
      6'h28: v = 9'o550; 6'h29: v = 9'o360; 6'h2A: v = 9'o261; 6'h2B: v = 9'o163;
      6'h2C: v = 9'o156; 6'h2D: v = 9'o111;
      6'h30: v = 9'o777; 6'h31: v = 9'o567; 6'h32: v = 9'o557; 6'h33: v = 9'o657;
      6'h34: v = 9'o757; 6'h35: v = 9'o756; 6'h36: v = 9'o755; 6'h37: v = 9'o764;
      6'h38: v = 9'o663; 6'h39: v = 9'o563; 6'h3A: v = 9'o574; 6'h3B: v = 9'o475;
      6'h3C: v = 9'o567; 6'h3D: v = 9'o555;
      default: v = 9'o000;
    endcase
    return v;
  endfunction

  assign fb.rgb_buf = r_rd_blank ? 9'h000 : f_palette(r_rd_data);
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire
